// File: rtl/channel_decoder_coef_pkg.sv
// Shared types and defaults for the channel decoder coefficient fetch path.
// Build with CHANNEL_DECODER_COEF_SYM_EN for symmetric-FIR (half-ROM) addressing.
package channel_decoder_coef_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 7;
    localparam int NUM_TAPS_DEF = 73;
    localparam int SKID_DEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/channel_decoder_coef_skid.sv
// Two-entry {last,data} FIFO that absorbs the one-cycle ROM read latency.
module channel_decoder_coef_skid
    import channel_decoder_coef_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(SKID_DEPTH);

    logic [SKID_DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]                rd_ptr, wr_ptr;
    logic                         push_ok, pop_ok;

    // A push into a full buffer is accepted only when the head leaves the same cycle.
    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count < 2'(SKID_DEPTH)) || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/channel_decoder_coef_fetch.sv
// Streams NUM_TAPS coefficients from a 1-cycle-latency ROM onto a valid/ready port.
// CHANNEL_DECODER_COEF_SYM_EN folds tap addresses onto a half-length symmetric ROM.
module channel_decoder_coef_fetch
    import channel_decoder_coef_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_TAPS = NUM_TAPS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address0,
    output logic              rom_ce0,
    input  logic [DATA_W-1:0] rom_q0,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

    state_t            state;
    logic [ADDR_W-1:0] tap_idx;
    logic              inflight;
    logic              cap_last;
    logic              done_r;
    logic [1:0]        fcount;
    logic [DATA_W:0]   head;
    logic [2:0]        occ;
    logic              pop;

    assign pop = m_valid && m_ready;
    assign occ = {1'b0, fcount} + {2'b00, inflight};

    // Entries held plus the read in flight, less what leaves now, must stay under two.
    assign rom_ce0 = (state == RUN) && (occ < (3'(SKID_DEPTH) + {2'b00, pop}));

`ifdef CHANNEL_DECODER_COEF_SYM_EN
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'((NUM_TAPS + 1) / 2);
    assign rom_address0 = (tap_idx < HALF) ? tap_idx : (LAST_IDX - tap_idx);
`else
    assign rom_address0 = tap_idx;
`endif

    assign busy = (state != IDLE);
    assign done = done_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tap_idx  <= '0;
            inflight <= 1'b0;
            cap_last <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            inflight <= rom_ce0;
            cap_last <= rom_ce0 && (tap_idx == LAST_IDX);
            done_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        tap_idx <= '0;
                    end
                end
                RUN: begin
                    // The index parks on the last tap so the address never runs past the table.
                    if (rom_ce0) begin
                        if (tap_idx == LAST_IDX)
                            state <= DRAIN;
                        else
                            tap_idx <= tap_idx + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    channel_decoder_coef_skid #(
        .W(DATA_W + 1)
    ) u_skid (
        .clk  (clk),
        .rst_n(reset),
        .push (inflight),
        .din  ({cap_last, rom_q0}),
        .pop  (pop),
        .count(fcount),
        .head (head)
    );

    assign m_valid = (fcount != 2'd0);
    assign m_data  = head[DATA_W-1:0];
    assign m_last  = m_valid && head[DATA_W];

endmodule

// File: tb/tb_channel_decoder_coef_fetch.sv
// Directed bench for channel_decoder_coef_fetch with a behavioural 1-cycle ROM.
module tb_channel_decoder_coef_fetch;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int NT = 73;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic          busy, done, rom_ce0, m_valid, m_last;
    logic [AW-1:0] rom_address0;
    logic [DW-1:0] rom_q0, m_data;
    logic [DW-1:0] rom [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int ce_q[$];
    int dq[$];
    int lq[$];
    int bcyc[$];
    int done_cnt, done_cyc, busy_first, busy_last, busy_n, bad_addr, stable_err;
    logic          pstall = 1'b0;
    logic [DW:0]   pval = '0;

    channel_decoder_coef_fetch #(.DATA_W(DW), .ADDR_W(AW), .NUM_TAPS(NT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rom_address0(rom_address0), .rom_ce0(rom_ce0), .rom_q0(rom_q0),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < (1 << AW); i++) rom[i] = 16'(i * 3 + 1);
    always @(posedge clk) if (rom_ce0) rom_q0 <= rom[rom_address0];

    always @(negedge clk) begin
        if (!reset) begin
            pstall = 1'b0;
        end else begin
            if (pstall && (!m_valid || ({m_last, m_data} != pval))) stable_err++;
            pstall = m_valid && !m_ready;
            pval   = {m_last, m_data};
            if (rom_ce0) begin
                ce_q.push_back(int'(rom_address0));
                if (int'(rom_address0) > NT - 1) bad_addr++;
            end
            if (m_valid && m_ready) begin
                dq.push_back(int'(m_data));
                lq.push_back(int'(m_last));
                bcyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) begin
                if (busy_n == 0) busy_first = cyc;
                busy_last = cyc;
                busy_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_addr(input int i);
`ifdef CHANNEL_DECODER_COEF_SYM_EN
        return (i < (NT + 1) / 2) ? i : (NT - 1 - i);
`else
        return i;
`endif
    endfunction

    function automatic int exp_data(input int i);
        return (exp_addr(i) * 3 + 1) & 16'hffff;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        ce_q.delete(); dq.delete(); lq.delete(); bcyc.delete();
        done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
        busy_n = 0; bad_addr = 0; stable_err = 0;
    endtask

    task automatic start_pass(output int t);
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_ready = 1'b1;
        chk({tag, "_timeout"}, (n < 4000) ? 32'd0 : 32'd1, 32'd0);
    endtask

    task automatic check_stream(input string tag);
        int dmis = 0, lmis = 0, amis = 0;
        chk({tag, "_beats"}, dq.size(), NT);
        chk({tag, "_issues"}, ce_q.size(), NT);
        for (int i = 0; i < dq.size() && i < NT; i++) begin
            if (dq[i] != exp_data(i)) dmis++;
            if (lq[i] != ((i == NT - 1) ? 1 : 0)) lmis++;
        end
        for (int i = 0; i < ce_q.size() && i < NT; i++)
            if (ce_q[i] != exp_addr(i)) amis++;
        chk({tag, "_data_mism"}, dmis, 0);
        chk({tag, "_last_mism"}, lmis, 0);
        chk({tag, "_addr_mism"}, amis, 0);
        chk({tag, "_addr_range"}, bad_addr, 0);
        chk({tag, "_stable"}, stable_err, 0);
    endtask

    initial begin
        int t, t2, n;
        bit p10, p40;
        clr_mon();
        m_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", rom_ce0, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_addr", rom_address0, 0);
        chk("rst_data", m_data, 0);
        reset = 1'b1;
        tick();

        // Full-rate pass: exact cycle placement of beats, done and busy.
        clr_mon();
        start_pass(t);
        wait_done(1'b0, "norm");
        check_stream("norm");
        chk("norm_first_beat", bcyc.size() > 0 ? bcyc[0] : -1, t + 3);
        chk("norm_last_beat", bcyc.size() > 0 ? bcyc[bcyc.size()-1] : -1, t + 2 + NT);
        chk("norm_last_data", dq.size() > 0 ? dq[dq.size()-1] : -1, exp_data(NT - 1));
        chk("norm_done_cnt", done_cnt, 1);
        chk("norm_done_cyc", done_cyc, t + 3 + NT);
        chk("norm_busy_first", busy_first, t + 1);
        chk("norm_busy_last", busy_last, t + 2 + NT);
        chk("norm_busy_n", busy_n, NT + 2);
        chk("norm_idle_busy", busy, 0);

        // Random backpressure passes.
        for (int s = 0; s < 20; s++) begin
            clr_mon();
            m_ready = 1'($urandom_range(0, 1));
            start_pass(t);
            wait_done(1'b1, "rnd");
            check_stream("rnd");
        end

        // Stall from the start: only two reads go out, then resume at address 2.
        clr_mon();
        m_ready = 1'b0;
        start_pass(t);
        repeat (10) tick();
        chk("stall_issues", ce_q.size(), 2);
        chk("stall_a0", ce_q.size() > 0 ? ce_q[0] : -1, 0);
        chk("stall_a1", ce_q.size() > 1 ? ce_q[1] : -1, 1);
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, exp_data(0));
        m_ready = 1'b1;
        tick();
        chk("stall_resume", ce_q.size() > 2 ? ce_q[2] : -1, 2);
        wait_done(1'b0, "stall");
        check_stream("stall");

        // Starts while busy are ignored; a start in the done cycle opens a new pass.
        clr_mon();
        p10 = 1'b0; p40 = 1'b0; n = 0;
        start_pass(t);
        while (!done && n < 4000) begin
            if (dq.size() >= 10 && !p10) begin start = 1'b1; p10 = 1'b1; end
            else if (dq.size() >= 40 && !p40) begin start = 1'b1; p40 = 1'b1; end
            else start = 1'b0;
            tick();
            n++;
        end
        chk("busy_start_timeout", (n < 4000) ? 32'd0 : 32'd1, 32'd0);
        start = 1'b1;
        t2 = cyc;
        tick();
        start = 1'b0;
        chk("busy_start_done_cnt", done_cnt, 1);
        check_stream("busy_start");
        clr_mon();
        wait_done(1'b0, "back2back");
        check_stream("back2back");
        chk("back2back_first", bcyc.size() > 0 ? bcyc[0] : -1, t2 + 3);

        // Asynchronous abort mid-pass.
        clr_mon();
        start_pass(t);
        n = 0;
        while (dq.size() < 20 && n < 200) begin tick(); n++; end
        reset = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, rom_ce0, m_valid, m_last, rom_address0, m_data}, 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", busy, 0);
        clr_mon();
        start_pass(t);
        wait_done(1'b0, "post_abort");
        check_stream("post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
